// File: rtl/unit_control_seq.sv
// Multicycle control sequencer: latches the opcode after fetch, holds decoded
// control levels for the instruction, and gates one-cycle strobes per stage.
module unit_control_seq #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = 3,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               stall,
    output logic [STAGE_W-1:0] stage,
    output logic               irWrite,
    output logic               PCWrite,
    output logic               memRead,
    output logic               memWrite,
    output logic               regWrite,
    output logic               push,
    output logic               pop,
    output logic               regDst,
    output logic               memToReg,
    output logic [2:0]         aluOp,
    output logic [2:0]         pcSrc,
    output logic [1:0]         data_a_select,
    output logic [1:0]         data_b_select,
    output logic               halted,
    output logic [COUNT_W-1:0] retired
);

    localparam logic [2:0] CLS_NOP   = 3'd0;
    localparam logic [2:0] CLS_ALU   = 3'd1;
    localparam logic [2:0] CLS_LOAD  = 3'd2;
    localparam logic [2:0] CLS_STORE = 3'd3;
    localparam logic [2:0] CLS_CTRL  = 3'd4;
    localparam logic [2:0] CLS_HALT  = 3'd5;

    localparam logic [STAGE_W-1:0] MEM_LAST   = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] ALU_LAST   = STAGE_W'(NUM_STAGES - 2);
    localparam logic [STAGE_W-1:0] SHORT_LAST = STAGE_W'(2);

    logic [STAGE_W-1:0] stage_q;
    logic [5:0]         op_q;
    logic               valid_q;
    logic               halted_q;
    logic [COUNT_W-1:0] retired_q;

    logic [2:0]         cls;
    logic               is_call;
    logic               is_ret;
    logic [STAGE_W-1:0] last_stage;
    logic               at_last;
    logic               active;

    // Decode only from the latched opcode so levels cannot move mid-instruction.
    always_comb begin
        regDst        = 1'b0;
        memToReg      = 1'b0;
        aluOp         = 3'b010;
        pcSrc         = 3'b010;
        data_a_select = 2'b00;
        data_b_select = 2'b00;
        cls           = CLS_NOP;
        is_call       = 1'b0;
        is_ret        = 1'b0;
        if (valid_q) begin
            case (op_q)
                6'b000000, 6'b011100, 6'b011101: begin
                    regDst = 1'b1; data_a_select = 2'b10; data_b_select = 2'b01; cls = CLS_ALU;
                end
                6'b001000: begin aluOp = 3'b000; data_a_select = 2'b10; cls = CLS_ALU; end
                6'b001001: begin aluOp = 3'b001; data_a_select = 2'b10; cls = CLS_ALU; end
                6'b001100: begin aluOp = 3'b011; data_a_select = 2'b10; cls = CLS_ALU; end
                6'b001101: begin aluOp = 3'b100; data_a_select = 2'b10; cls = CLS_ALU; end
                6'b100011: begin
                    memToReg = 1'b1; aluOp = 3'b000; data_a_select = 2'b10; cls = CLS_LOAD;
                end
                6'b101011: begin aluOp = 3'b000; data_a_select = 2'b10; cls = CLS_STORE; end
                6'b010001: begin aluOp = 3'b000; pcSrc = 3'b001; cls = CLS_CTRL; end
                6'b000010: begin
                    aluOp = 3'b000; pcSrc = 3'b100; data_b_select = 2'b10; cls = CLS_CTRL;
                end
                6'b000100: begin
                    aluOp = 3'b101; pcSrc = 3'b001; data_a_select = 2'b10; cls = CLS_CTRL;
                end
                6'b000011: begin aluOp = 3'b000; pcSrc = 3'b001; cls = CLS_CTRL; is_call = 1'b1; end
                6'b000001: begin aluOp = 3'b000; pcSrc = 3'b000; cls = CLS_CTRL; is_ret = 1'b1; end
                6'b111111: begin aluOp = 3'b000; pcSrc = 3'b101; cls = CLS_HALT; end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (cls)
            CLS_LOAD, CLS_STORE: last_stage = MEM_LAST;
            CLS_ALU:             last_stage = ALU_LAST;
            default:             last_stage = SHORT_LAST;
        endcase
    end

    assign at_last = (stage_q == last_stage);
    assign active  = !stall && !halted_q;

    assign irWrite  = active && (stage_q == '0);
    assign memRead  = active && (stage_q == ALU_LAST) && (cls == CLS_LOAD);
    assign memWrite = active && (stage_q == ALU_LAST) && (cls == CLS_STORE);
    assign regWrite = active && at_last && ((cls == CLS_ALU) || (cls == CLS_LOAD));
    assign push     = active && (stage_q == SHORT_LAST) && is_call;
    assign pop      = active && (stage_q == SHORT_LAST) && is_ret;
    assign PCWrite  = active && at_last && (cls != CLS_HALT);

    // Halt and stall both freeze every register; only reset breaks a halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q   <= '0;
            op_q      <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else if (active) begin
            if (stage_q == '0) begin
                op_q    <= opcode;
                valid_q <= 1'b1;
            end
            if (at_last) begin
                stage_q <= '0;
                if (cls == CLS_HALT)
                    halted_q <= 1'b1;
            end else begin
                stage_q <= stage_q + 1'b1;
            end
            if (PCWrite)
                retired_q <= retired_q + 1'b1;
        end
    end

    assign stage   = stage_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule
